// File: rtl/addsub_pipe_pkg.sv
// addsub_pipe shared defines, opcode encodings and flag bundle.
// Included first; every other file imports addsub_pipe_pkg::*.
`ifndef ADDSUB_PIPE_DEFS
`define ADDSUB_PIPE_DEFS
`define DATA_WIDTH 8
`define ADDSUB_OP_ADD  3'b000
`define ADDSUB_OP_SUB  3'b001
`define ADDSUB_OP_ADDC 3'b010
`define ADDSUB_OP_SUBB 3'b011
`define ADDSUB_OP_ADDS 3'b100
`define ADDSUB_OP_SUBS 3'b101
`endif

package addsub_pipe_pkg;

   localparam logic [2:0] OP_ADD  = `ADDSUB_OP_ADD;
   localparam logic [2:0] OP_SUB  = `ADDSUB_OP_SUB;
   localparam logic [2:0] OP_ADDC = `ADDSUB_OP_ADDC;
   localparam logic [2:0] OP_SUBB = `ADDSUB_OP_SUBB;
   localparam logic [2:0] OP_ADDS = `ADDSUB_OP_ADDS;
   localparam logic [2:0] OP_SUBS = `ADDSUB_OP_SUBS;

   typedef struct packed {
      logic carry;
      logic ovf;
      logic zero;
      logic neg;
   } flags_t;

endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe operand/result handshake bundle.
// master = producer/consumer side, slave = the pipeline.
interface addsub_pipe_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic [2:0]            in_op;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_carry;
   logic                  out_ovf;
   logic                  out_zero;
   logic                  out_neg;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_data,
      input  out_carry, out_ovf, out_zero, out_neg
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_data,
      output out_carry, out_ovf, out_zero, out_neg
   );
endinterface

// File: rtl/addsub_core.sv
// addsub_core: combinational add/sub with carry chain,
// signed overflow detection and optional saturation.
module addsub_core
   import addsub_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter bit SAT_EN     = 1'b1
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [2:0]            op_i,
   input  logic                  cf_i,
   output logic [DATA_WIDTH-1:0] res_o,
   output flags_t                flags_o,
   output logic                  cf_upd_o
);

   localparam int MSB = DATA_WIDTH - 1;

   logic                  sub;
   logic                  sat;
   logic                  cin;
   logic                  rsvd;
   logic [DATA_WIDTH-1:0] bx;
   logic [DATA_WIDTH:0]   sum;
   logic                  ovf;

   always_comb begin
      sub  = 1'b0;
      sat  = 1'b0;
      cin  = 1'b0;
      rsvd = 1'b0;
      unique case (op_i)
         OP_ADD:  cin = 1'b0;
         OP_SUB:  begin sub = 1'b1; cin = 1'b1; end
         OP_ADDC: cin = cf_i;
         OP_SUBB: begin sub = 1'b1; cin = cf_i; end
         OP_ADDS: sat = SAT_EN;
         OP_SUBS: begin sub = 1'b1; cin = 1'b1; sat = SAT_EN; end
         default: rsvd = 1'b1;
      endcase

      bx  = sub ? ~b_i : b_i;
      sum = {1'b0, a_i} + {1'b0, bx}
          + {{DATA_WIDTH{1'b0}}, cin};
      ovf = (a_i[MSB] == bx[MSB]) && (sum[MSB] != a_i[MSB]);

      res_o = sum[MSB:0];
      // Clamp toward the operand sign; carry stays unsaturated.
      if (sat && ovf)
         res_o = a_i[MSB] ? {1'b1, {MSB{1'b0}}}
                          : {1'b0, {MSB{1'b1}}};

      flags_o.carry = sum[DATA_WIDTH];
      flags_o.ovf   = ovf;
      flags_o.zero  = (res_o == '0);
      flags_o.neg   = res_o[MSB];

      if (rsvd) begin
         res_o   = '0;
         flags_o = '0;
      end
      cf_upd_o = !rsvd;
   end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready add/sub pipeline.
// S1 holds operands, S2 holds result, flags and carry flag.
module addsub_pipe
   import addsub_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter bit SAT_EN     = 1'b1
) (
   input logic          clk,
   input logic          rst,
   addsub_pipe_if.slave bus
);

   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
   logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]            s1_op_q, s1_op_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
   flags_t                s2_flags_q, s2_flags_d;
   logic                  cf_q, cf_d;

   logic                  s2_free;
   logic                  s1_adv;
   logic [DATA_WIDTH-1:0] core_res;
   flags_t                core_flags;
   logic                  core_cf_upd;

   addsub_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .SAT_EN     (SAT_EN)
   ) u_core (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .op_i     (s1_op_q),
      .cf_i     (cf_q),
      .res_o    (core_res),
      .flags_o  (core_flags),
      .cf_upd_o (core_cf_upd)
   );

   assign s2_free      = !s2_valid_q || bus.out_ready;
   assign s1_adv       = s1_valid_q && s2_free;
   assign bus.in_ready = !rst && (!s1_valid_q || s1_adv);

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_flags_d = s2_flags_q;
      cf_d       = cf_q;

      // in_ready means S1 is empty or emptying this cycle.
      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b;
            s1_op_d = bus.in_op;
         end
      end

      if (s2_free)
         s2_valid_d = s1_valid_q;
      if (s1_adv) begin
         s2_data_d  = core_res;
         s2_flags_d = core_flags;
         if (core_cf_upd)
            cf_d = core_flags.carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_flags_q <= '0;
         cf_q       <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_flags_q <= s2_flags_d;
         cf_q       <= cf_d;
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_carry = s2_flags_q.carry;
   assign bus.out_ovf   = s2_flags_q.ovf;
   assign bus.out_zero  = s2_flags_q.zero;
   assign bus.out_neg   = s2_flags_q.neg;

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (shared define), meaning operand/result width in bits, legal range 2..64.
REQ-002 SHALL have parameter SAT_EN, default 1, meaning saturating ops present (0: ADDS/SUBS behave as ADD/SUB).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block accepts operand set this cycle.
REQ-008 in_a, in_b  input  DATA_WIDTH each  operands.
REQ-009 in_op  input  3  opcode: 000 ADD, 001 SUB, 010 ADDC, 011 SUBB, 100 ADDS, 101 SUBS; 110/111 reserved.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_data  output  DATA_WIDTH  result.
REQ-013 out_carry, out_ovf, out_zero, out_neg  output  1 each  carry/no-borrow, signed overflow, result==0, result MSB.

Function
REQ-014 SHALL transfer input when in_valid&in_ready and output when out_valid&out_ready.
REQ-015 SHALL be 2 register stages: S1 registers a, b, op; combinational compute S1->S2; S2 registers result and flags.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled; throughput 1 op/cycle.
REQ-017 Each stage SHALL advance when downstream empty or draining same cycle; in_ready = !S1_valid | S1_advances (no combinational path in_valid->in_ready).
REQ-018 With out_ready low, block SHALL hold at most 2 ops, then in_ready=0; no op dropped, duplicated or reordered.
REQ-019 ADD: a+b, carry-in 0; SUB: a+~b+1; carry = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum (SUB: 1 = no borrow).
REQ-020 ADDC/SUBB SHALL use internal carry flag as carry-in (SUBB: a+~b+cf).
REQ-021 Carry flag SHALL update to out_carry of each op entering S2; op in S1 always sees carry of the immediately preceding op.
REQ-022 Overflow SHALL be set when operand signs (b inverted for sub) agree and result sign differs.
REQ-023 ADDS/SUBS SHALL clamp on overflow to 0x7F..F (positive) or 0x80..0 (negative), out_ovf=1; out_carry computed as unsaturated.
REQ-024 out_zero/out_neg SHALL reflect final (post-saturation) out_data.
REQ-025 Reserved opcodes SHALL produce out_data=0, all flags 0, carry flag unchanged.
REQ-026 Outputs SHALL hold stable while out_valid&!out_ready.

Reset
REQ-027 On rst: S1/S2 valid=0, out_valid=0, out_data=0, all flags 0, carry flag 0, in_ready=0 during rst and 1 the cycle after.
REQ-028 Reset mid-operation SHALL discard in-flight ops; none emerges after reset.

Structure
REQ-029 Opcode encodings and DATA_WIDTH default SHALL live in the shared define file.
REQ-030 Compute SHALL be a combinational sub-module addsub_core (a, b, op, cin -> result, flags); addsub_pipe holds stages and handshake.

Verification (DATA_WIDTH=8, SAT_EN=1)
REQ-031 ADD 0xFF,0x01 -> 2 cycles later out_data 0x00, carry 1, zero 1, ovf 0.
REQ-032 SUB 0x80,0x01 -> 0x7F, carry 1, ovf 1, neg 0; ADDS 0x7F,0x01 -> 0x7F, ovf 1; SUBS 0x80,0x01 -> 0x80, ovf 1.
REQ-033 Back-to-back ADD 0xFF,0x01 then ADDC 0x00,0x00 -> results 0x00 then 0x01; SUBB 0x00,0x00 after SUB 0x00,0x01 -> 0xFF.
REQ-034 Stream 5 ops, out_ready=0 for cycles 2-6 -> in_ready=0 after 2 held ops, all 5 results in order, each exactly once.
REQ-035 Assert rst with 2 ops in flight -> out_valid 0 next cycle, no stale result, carry flag 0 (ADDC 0x01,0x01 -> 0x02).
REQ-036 Opcode 111 -> out_data 0, flags 0; following ADDC unaffected by it.
